// File: rtl/fetch_stage.sv
// Fetch stage of the 2-stage pipeline: program counter, ROM addressing and the
// instruction register feeding the execute stage, with JMP/JNC redirect and bubble.
module fetch_stage #(
  parameter int PC_WIDTH  = 4,
  parameter int RESET_PC  = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 carry_flag,
  output logic [PC_WIDTH-1:0]  rom_addr,
  input  logic [7:0]           rom_data,
  output logic [7:0]           D_BUS,
  output logic                 ir_valid,
  output logic [PC_WIDTH-1:0]  pc_dbg,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(RESET_PC);
  localparam logic [7:0]          BUBBLE   = 8'h00;
  localparam logic [2:0]          OP_JUMPS = 3'b111;

  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [7:0]           ir_q, ir_d;
  logic                 vld_q, vld_d;
  logic [PC_WIDTH-1:0]  pc_dbg_q, pc_dbg_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 jmp_slot;
  logic                 taken;

  // Immediate field is 4 bits; the size cast zero-extends or truncates to PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] jump_target(input logic [3:0] imm);
    return PC_WIDTH'(imm);
  endfunction

  // Opcode 1111 always jumps; 1110 jumps only when carry is clear.
  assign jmp_slot = vld_q & (ir_q[7:5] == OP_JUMPS);
  assign taken    = jmp_slot & (ir_q[4] | ~carry_flag);

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    vld_d    = vld_q;
    pc_dbg_d = pc_dbg_q;
    cnt_d    = cnt_q;
    if (!stall) begin
      if (jmp_slot) begin
        // The word fetched this cycle is dropped; a not-taken jump refetches it.
        if (taken) pc_d = jump_target(ir_q[3:0]);
        ir_d  = BUBBLE;
        vld_d = 1'b0;
      end else begin
        ir_d     = rom_data;
        vld_d    = 1'b1;
        pc_dbg_d = pc_q;
        pc_d     = pc_q + PC_WIDTH'(1);
        cnt_d    = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q     <= PC_RST;
      ir_q     <= BUBBLE;
      vld_q    <= 1'b0;
      pc_dbg_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      vld_q    <= vld_d;
      pc_dbg_q <= pc_dbg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rom_addr    = pc_q;
  assign D_BUS       = ir_q;
  assign ir_valid    = vld_q;
  assign pc_dbg      = pc_dbg_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural fetch model pushes expected outputs per edge
// into a scoreboard queue; directed checks pin the key values of each scenario.
module tb_fetch_stage;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic       carry_flag = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] D_BUS;
  logic       ir_valid;
  logic [3:0] pc_dbg;
  logic [7:0] fetch_count;

  logic [7:0] rom [16];
  assign rom_data = rom[rom_addr];

  fetch_stage #(.PC_WIDTH(4), .RESET_PC(0), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .stall(stall), .carry_flag(carry_flag),
    .rom_addr(rom_addr), .rom_data(rom_data), .D_BUS(D_BUS), .ir_valid(ir_valid),
    .pc_dbg(pc_dbg), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] d;
    logic       v;
    logic [3:0] pd;
    logic [7:0] c;
  } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total  = 0;

  logic [3:0] m_pc, m_pd;
  logic [7:0] m_ir, m_cnt;
  logic       m_vld;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 4'd0; m_ir = 8'h00; m_vld = 1'b0; m_pd = 4'd0; m_cnt = 8'd0;
  endtask

  function automatic exp_t model_now();
    exp_t e;
    e.addr = m_pc; e.d = m_ir; e.v = m_vld; e.pd = m_pd; e.c = m_cnt;
    return e;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic js;
    if (!stall) begin
      js = m_vld && (m_ir[7:5] == 3'b111);
      if (js) begin
        if (m_ir[4] || !carry_flag) m_pc = m_ir[3:0];
        m_ir  = 8'h00;
        m_vld = 1'b0;
      end else begin
        m_ir  = rom[m_pc];
        m_vld = 1'b1;
        m_pd  = m_pc;
        m_pc  = m_pc + 4'd1;
        m_cnt = m_cnt + 8'd1;
      end
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_addr"}, {4'h0, rom_addr}, {4'h0, e.addr});
    chk({tag, "_dbus"}, D_BUS, e.d);
    chk({tag, "_vld"},  {7'h0, ir_valid}, {7'h0, e.v});
    chk({tag, "_pcdbg"}, {4'h0, pc_dbg}, {4'h0, e.pd});
    chk({tag, "_cnt"},  fetch_count, e.c);
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic step(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      sb.push_back(model_now());
      @(posedge clock);
      #1;
      pop_check(tag);
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    sb.push_back(model_now());
    pop_check("rst_async");
    @(posedge clock);
    #1;
    sb.push_back(model_now());
    pop_check("rst_held");
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic rom_ramp();
    for (int i = 0; i < 16; i++) rom[i] = 8'h10 + 8'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    model_reset();
    @(negedge clock);

    // Test 1: reset values and first fetch
    rom[0] = 8'h31;
    do_reset();
    chk("t1_rst_addr", {4'h0, rom_addr}, 8'h00);
    step("t1", 1);
    chk("t1_dbus", D_BUS, 8'h31);
    chk("t1_vld", {7'h0, ir_valid}, 8'h01);
    chk("t1_addr", {4'h0, rom_addr}, 8'h01);
    chk("t1_cnt", fetch_count, 8'd1);

    // Test 2: straight-line run with PC wrap
    for (int i = 0; i < 16; i++) rom[i] = 8'h01;
    do_reset();
    step("t2", 20);
    chk("t2_cnt", fetch_count, 8'd20);
    chk("t2_addr", {4'h0, rom_addr}, 8'h04);
    chk("t2_vld", {7'h0, ir_valid}, 8'h01);

    // Test 3: unconditional JMP to 7
    rom_ramp();
    rom[2] = 8'hF7;
    do_reset();
    step("t3", 3);
    chk("t3_jmp_dbus", D_BUS, 8'hF7);
    step("t3", 1);
    chk("t3_bub_vld", {7'h0, ir_valid}, 8'h00);
    chk("t3_bub_addr", {4'h0, rom_addr}, 8'h07);
    chk("t3_bub_cnt", fetch_count, 8'd3);
    step("t3", 1);
    chk("t3_tgt_dbus", D_BUS, 8'h17);
    chk("t3_tgt_pcdbg", {4'h0, pc_dbg}, 8'h07);

    // Test 4: JNC not taken (carry=1) then taken (carry=0)
    rom_ramp();
    rom[3] = 8'hE9;
    carry_flag = 1'b1;
    do_reset();
    step("t4a", 4);
    step("t4a", 1);
    chk("t4a_bub_addr", {4'h0, rom_addr}, 8'h04);
    step("t4a", 1);
    chk("t4a_dbus", D_BUS, 8'h14);
    carry_flag = 1'b0;
    do_reset();
    step("t4b", 4);
    step("t4b", 1);
    chk("t4b_bub_addr", {4'h0, rom_addr}, 8'h09);
    step("t4b", 1);
    chk("t4b_dbus", D_BUS, 8'h19);

    // Test 5: stall holds a pending jump
    rom_ramp();
    rom[2] = 8'hF7;
    do_reset();
    step("t5", 3);
    stall = 1'b1;
    step("t5_stall", 3);
    chk("t5_frz_dbus", D_BUS, 8'hF7);
    chk("t5_frz_addr", {4'h0, rom_addr}, 8'h03);
    chk("t5_frz_cnt", fetch_count, 8'd3);
    stall = 1'b0;
    step("t5", 1);
    chk("t5_bub_vld", {7'h0, ir_valid}, 8'h00);
    chk("t5_bub_addr", {4'h0, rom_addr}, 8'h07);

    // Test 6: asynchronous reset pulse mid-cycle
    rom_ramp();
    do_reset();
    step("t6", 9);
    chk("t6_addr9", {4'h0, rom_addr}, 8'h09);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_addr", {4'h0, rom_addr}, 8'h00);
    chk("t6_async_dbus", D_BUS, 8'h00);
    chk("t6_async_vld", {7'h0, ir_valid}, 8'h00);
    chk("t6_async_cnt", fetch_count, 8'h00);
    #1 reset = 1'b0;
    model_reset();
    step("t6", 1);
    chk("t6_restart_dbus", D_BUS, 8'h10);
    chk("t6_restart_addr", {4'h0, rom_addr}, 8'h01);

    // Back-to-back jumps, then randomised ROM, stall and carry
    rom_ramp();
    rom[1] = 8'hF3;
    rom[3] = 8'hE5;
    carry_flag = 1'b0;
    do_reset();
    step("b2b", 6);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      do_reset();
      for (int k = 0; k < 60; k++) begin
        stall      = ($urandom_range(0, 3) == 0);
        carry_flag = 1'($urandom_range(0, 1));
        step("rnd", 1);
      end
      stall = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
